// File: rtl/button_state_ctrl.sv
// Debounced, synchronised key front end. Each key has its own FSM and produces a
// held level, single-cycle press/release pulses and optional auto-repeat presses.
module button_state_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b0011,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic [3:0] btn_state,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] k;

  // Sync stages reset to the released level so no event appears on reset exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign k = ~sync2;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             rep_q, rep_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rep_q   <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rep_q   <= rep_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (k[gi]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!k[gi]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= DEB_MAX) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (!k[gi]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
            rep_d   = 1'b0;
          end else if (REPEAT_MASK[gi]) begin
            // First tick waits the hold time, later ticks the repeat period.
            if (cnt_q >= (rep_q ? REP_MAX : HOLD_MAX)) begin
              cnt_d   = '0;
              press_d = 1'b1;
              rep_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        RELEASE_WAIT: begin
          if (k[gi]) begin
            state_d = HELD;
            cnt_d   = '0;
            rep_d   = 1'b0;
          end else if (cnt_q >= DEB_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          rep_d   = 1'b0;
          level_d = 1'b0;
        end
      endcase
    end

    assign btn_state[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = rel_q;
  end

endmodule

// File: tb/tb_button_state_ctrl.sv
// Bench for button_state_ctrl: directed scenarios with literal timing checks,
// then random key activity checked every cycle against a run-length model.
module tb_button_state_ctrl;

  localparam int          D    = 4;
  localparam int          H    = 10;
  localparam int          R    = 5;
  localparam logic [3:0]  MASK = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] btn_state, btn_press, btn_release;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_state_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .REPEAT_MASK(MASK),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .btn_state(btn_state),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  // Model: a key's level flips once D+1 consecutive synced samples disagree
  // with it; repeats fire when the held-sample count hits H, H+R, H+2R, ...
  logic [3:0] m_s1, m_s2, m_level, m_press, m_rel;
  int m_run[4];
  int m_held[4];

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] kk, lvl, pr, rl;
    int run, held;
    if (!rst_n) begin
      m_s1    <= '1;
      m_s2    <= '1;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i]  <= 0;
        m_held[i] <= 0;
      end
    end else begin
      kk  = ~m_s2;
      lvl = m_level;
      pr  = '0;
      rl  = '0;
      for (int i = 0; i < 4; i++) begin
        run  = m_run[i];
        held = m_held[i];
        if (kk[i] != lvl[i]) begin
          run = run + 1;
          if (run == D + 1) begin
            lvl[i] = ~lvl[i];
            run    = 0;
            held   = 0;
            if (lvl[i]) pr[i] = 1'b1;
            else        rl[i] = 1'b1;
          end
        end else if (run != 0) begin
          run  = 0;
          held = 0;
        end else if (lvl[i] && MASK[i]) begin
          held = held + 1;
          if (held >= H && ((held - H) % R) == 0) pr[i] = 1'b1;
        end
        m_run[i]  <= run;
        m_held[i] <= held;
      end
      m_s2    <= m_s1;
      m_s1    <= key_n;
      m_level <= lvl;
      m_press <= pr;
      m_rel   <= rl;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if ({btn_state, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
      miscompares++;
      $display("FAIL outputs t=%0t: got state=%b press=%b release=%b, expected state=%b press=%b release=%b",
               $time, btn_state, btn_press, btn_release, m_level, m_press, m_rel);
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int ptimes[$];
  int rtimes[$];
  int first_state;

  // Times are in clocks after the first edge that samples the stimulus change.
  task automatic watch(input int n, input int key, input int base);
    ptimes.delete();
    rtimes.delete();
    first_state = -1;
    repeat (n) begin
      @(negedge clk);
      if (btn_press[key])   ptimes.push_back(cyc - base - 1);
      if (btn_release[key]) rtimes.push_back(cyc - base - 1);
      if (btn_state[key] && first_state < 0) first_state = cyc - base - 1;
    end
  endtask

  function automatic int qget(input int idx);
    return (idx < ptimes.size()) ? ptimes[idx] : -1;
  endfunction

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int exp3[6];
    int hold[4];
    exp3 = '{6, 16, 21, 26, 31, 36};
    rst_n = 1'b0;
    key_n = '1;
    repeat (3) @(negedge clk);
    check_int("reset_outputs", int'({btn_state, btn_press, btn_release}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Short glitch on key 2 is rejected
    key_n[2] = 1'b0;
    base = cyc;
    repeat (3) @(negedge clk);
    key_n[2] = 1'b1;
    watch(12, 2, base);
    check_int("glitch_presses", ptimes.size(), 0);
    check_int("glitch_state", first_state, -1);

    // Steady press on key 2, no repeat
    @(negedge clk);
    key_n[2] = 1'b0;
    base = cyc;
    watch(30, 2, base);
    check_int("k2_press_count", ptimes.size(), 1);
    check_int("k2_press_time", qget(0), 6);
    check_int("k2_state_rise", first_state, 6);
    key_n[2] = 1'b1;
    repeat (15) @(negedge clk);

    // Auto-repeat on key 0
    key_n[0] = 1'b0;
    base = cyc;
    watch(40, 0, base);
    check_int("k0_press_count", ptimes.size(), 6);
    for (int i = 0; i < 6; i++) check_int($sformatf("k0_press_%0d", i), qget(i), exp3[i]);
    key_n[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Release bounce on key 1 absorbed, then real release
    key_n[1] = 1'b0;
    repeat (20) @(negedge clk);
    key_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    key_n[1] = 1'b0;
    base = cyc;
    watch(15, 1, base);
    check_int("k1_bounce_release", rtimes.size(), 0);
    check_int("k1_bounce_state", int'(btn_state[1]), 1);
    key_n[1] = 1'b1;
    base = cyc;
    watch(15, 1, base);
    check_int("k1_release_count", rtimes.size(), 1);
    check_int("k1_release_time", (rtimes.size() > 0) ? rtimes[0] : -1, 6);
    repeat (5) @(negedge clk);

    // Simultaneous keys 0 and 2
    key_n[0] = 1'b0;
    key_n[2] = 1'b0;
    base = cyc;
    watch(8, 2, base);
    check_int("k2_simul_press", qget(0), 6);
    check_int("simul_state", int'(btn_state), 5);

    // Async reset while held, re-accept after release
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_int("async_reset", int'({btn_state, btn_press, btn_release}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    watch(12, 0, base);
    check_int("rst_reaccept_time", first_state, 6);
    check_int("rst_no_release", rtimes.size(), 0);
    check_int("rst_reaccept_state", int'(btn_state), 5);
    key_n = '1;
    repeat (15) @(negedge clk);

    // Random key activity with occasional resets
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          key_n[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : $urandom_range(1, 8);
        end else begin
          hold[i]--;
        end
      end
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
